// File: rtl/half_adder_pkg.sv
// Shared constants for the registered half adder: default and maximum lane count.
package half_adder_pkg;

  localparam int HA_WIDTH_DEF = 1;
  localparam int HA_WIDTH_MAX = 64;

  function automatic bit ha_width_legal(input int w);
    return (w >= 1) && (w <= HA_WIDTH_MAX);
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One half-adder lane: purely combinational sum (XOR) and carry (AND).
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered, valid/ready half adder: WIDTH independent lanes, one-cycle latency,
// a single output register that sustains full throughput.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  if (!ha_width_legal(WIDTH)) begin : g_width_check
    $error("half_adder: WIDTH=%0d outside 1..%0d", WIDTH, HA_WIDTH_MAX);
  end

  logic [WIDTH-1:0] sum_p0;
  logic [WIDTH-1:0] carry_p0;
  logic [WIDTH-1:0] sum_p1;
  logic [WIDTH-1:0] carry_p1;
  logic             vld_p1;
  logic             in_xfer;

  // Stage p0: combinational lane results from the operands
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .s (sum_p0[i]),
      .c (carry_p0[i])
    );
  end

  // The register may be refilled in the same cycle it is drained.
  assign in_ready = !vld_p1 || out_ready;
  assign in_xfer  = in_valid && in_ready;

  // Stage p1: output register; operands are only sampled on an input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      sum_p1   <= '0;
      carry_p1 <= '0;
    end else if (in_xfer) begin
      vld_p1   <= 1'b1;
      sum_p1   <= sum_p0;
      carry_p1 <= carry_p0;
    end else if (out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign sum       = sum_p1;
  assign carry     = carry_p1;

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: a WIDTH=4 and a WIDTH=1 instance share handshake
// controls; expected results are queued on input transfer and popped on output transfer.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] a4, b4;
  logic       a1, b1;

  logic       rdy4, ov4;
  logic [3:0] s4, c4;
  logic       rdy1, ov1;
  logic [0:0] s1, c1;

  typedef struct packed {
    logic [3:0] s;
    logic [3:0] c;
  } res_t;

  res_t q4[$];
  res_t q1[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (rdy4),
    .a         (a4),
    .b         (b4),
    .out_valid (ov4),
    .out_ready (out_ready),
    .sum       (s4),
    .carry     (c4)
  );

  half_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (rdy1),
    .a         (a1),
    .b         (b1),
    .out_valid (ov1),
    .out_ready (out_ready),
    .sum       (s1),
    .carry     (c1)
  );

  // Reference: each lane counts how many of its two input bits are set;
  // the count's low bit is the sum and its twos bit is the carry.
  function automatic res_t model(input logic [3:0] a, input logic [3:0] b);
    res_t r;
    for (int i = 0; i < 4; i++) begin
      int ones;
      ones   = (a[i] ? 1 : 0) + (b[i] ? 1 : 0);
      r.s[i] = (ones % 2) == 1;
      r.c[i] = (ones / 2) == 1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: observes registered state at the falling edge and retires results.
  always @(negedge clk) begin
    check("in_ready4", {63'd0, rdy4}, {63'd0, (!ov4 || out_ready)});
    check("in_ready1", {63'd0, rdy1}, {63'd0, (!ov1 || out_ready)});
    check("out_valid4", {63'd0, ov4}, {63'd0, (q4.size() != 0)});
    check("out_valid1", {63'd0, ov1}, {63'd0, (q1.size() != 0)});
    if (ov4 && q4.size() != 0) begin
      check("sum4", {60'd0, s4}, {60'd0, q4[0].s});
      check("carry4", {60'd0, c4}, {60'd0, q4[0].c});
      if (out_ready) void'(q4.pop_front());
    end
    if (ov1 && q1.size() != 0) begin
      check("sum1", {63'd0, s1}, {63'd0, q1[0].s[0]});
      check("carry1", {63'd0, c1}, {63'd0, q1[0].c[0]});
      if (out_ready) void'(q1.pop_front());
    end
  end

  // One clock of stimulus; called just after a rising edge.
  task automatic cycle(input logic iv, input logic [3:0] a, input logic [3:0] b, input logic ordy);
    logic x4, x1;
    in_valid  = iv;
    out_ready = ordy;
    a4 = iv ? a : 4'bxxxx;
    b4 = iv ? b : 4'bxxxx;
    a1 = iv ? a[0] : 1'bx;
    b1 = iv ? b[0] : 1'bx;
    @(negedge clk);
    x4 = iv && rdy4 && rst_n;
    x1 = iv && rdy1 && rst_n;
    @(posedge clk);
    if (x4) q4.push_back(model(a, b));
    if (x1) q1.push_back(model(a, b));
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ov4"}, {63'd0, ov4}, 64'd0);
    check({tag, "_sum4"}, {60'd0, s4}, 64'd0);
    check({tag, "_carry4"}, {60'd0, c4}, 64'd0);
    check({tag, "_rdy4"}, {63'd0, rdy4}, 64'd1);
    check({tag, "_ov1"}, {63'd0, ov1}, 64'd0);
    check({tag, "_sum1"}, {63'd0, s1}, 64'd0);
    check({tag, "_rdy1"}, {63'd0, rdy1}, 64'd1);
  endtask

  initial begin
    // Reset with live operands present
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a4 = 4'hF; b4 = 4'hF; a1 = 1'b1; b1 = 1'b1;
    #1;
    check_cleared("reset");
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset_hold");
    rst_n = 1'b1;

    // Exhaustive lane-0 truth table, back-to-back with out_ready high
    cycle(1'b1, 4'b0000, 4'b0000, 1'b1);
    cycle(1'b1, 4'b0000, 4'b0001, 1'b1);
    cycle(1'b1, 4'b0001, 4'b0000, 1'b1);
    cycle(1'b1, 4'b0001, 4'b0001, 1'b1);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b1);

    // Backpressure: (1,1) held while (0,1) waits
    cycle(1'b1, 4'b1111, 4'b1111, 1'b0);
    repeat (3) cycle(1'b1, 4'b0000, 4'b1111, 1'b0);
    cycle(1'b1, 4'b0000, 4'b1111, 1'b1);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b1);

    // Simultaneous drain and refill, then the multi-lane pattern
    cycle(1'b1, 4'b0101, 4'b0011, 1'b1);
    cycle(1'b1, 4'b0001, 4'b0000, 1'b1);
    cycle(1'b1, 4'b1100, 4'b1010, 1'b1);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b1);

    // Mid-operation reset while a (1,1) result is held
    cycle(1'b1, 4'b1111, 4'b1111, 1'b0);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    q4.delete();
    q1.delete();
    #1;
    check_cleared("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 4'b0110, 4'b0011, 1'b1);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b1);

    // Randomized traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom % 4) != 0, 4'($urandom), 4'($urandom), ($urandom % 3) != 0);
    end
    repeat (3) cycle(1'b0, 4'b0000, 4'b0000, 1'b1);

    check("drain4", 64'(q4.size()), 64'd0);
    check("drain1", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/half_adder.md
# half_adder

Registered, handshaked half adder: adds two operands lane-by-lane and returns per-lane sum (XOR) and carry (AND) one clock after acceptance. It is the basic arithmetic leaf for ripple/carry-save adder trees and for bring-up arithmetic checks. Each lane is independent; there is no carry propagation between lanes.

## Interface
Parameters:
- WIDTH, 1, number of independent 1-bit half-adder lanes (legal range 1..64).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b present this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- out_valid  output  1  sum/carry hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  per-lane a XOR b, registered.
- carry  output  WIDTH  per-lane a AND b, registered.

## Operation
- Per lane i: sum[i] = a[i] ^ b[i], carry[i] = a[i] & b[i]. Truth table: 00->s0 c0, 01->s1 c0, 10->s1 c0, 11->s0 c1.
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational; single output register, full throughput).
- On input transfer: sum/carry registers load the new result, out_valid set to 1.
- On output transfer without a simultaneous input transfer: out_valid cleared; sum/carry retain their last value.
- Simultaneous output and input transfer in one cycle: new result loaded, out_valid stays 1 (no bubble).
- While out_valid=1 and out_ready=0: sum, carry and out_valid are held stable; in_ready=0; a/b ignored.
- in_valid=0: no register update regardless of a/b values (X on a/b must not propagate).
- Lanes never interact; WIDTH=1 is the canonical configuration.

## Timing
- Reset (rst_n low, asynchronous assertion, synchronous-to-clk deassertion handled externally): out_valid=0, sum=0, carry=0 immediately; in_ready therefore 1.
- Reset asserted mid-operation discards any held result; no output transfer occurs in that cycle.
- Latency: 1 cycle from input transfer edge to out_valid=1 with result on sum/carry.
- Throughput: one operand pair per cycle when out_ready is held high.
- No combinational path from a/b to sum/carry; only out_ready -> in_ready is combinational.

## Structure
- Shared package half_adder_pkg: WIDTH default constant (1) and max legal width (64).
- One sub-module natural: half_adder_cell (purely combinational 1-bit XOR/AND), instantiated WIDTH times via generate; top level holds output register, valid flag and ready logic.
- Elaboration-time check rejects WIDTH outside 1..64.

## Test plan
- Exhaustive WIDTH=1, out_ready=1: drive (a,b)=(0,0),(0,1),(1,0),(1,1) on consecutive cycles -> one cycle later sum/carry = 0/0, 1/0, 1/0, 0/1, out_valid=1 each cycle.
- Reset: hold rst_n=0 with in_valid=1, a=1, b=1 -> sum=0, carry=0, out_valid=0, in_ready=1; release -> first accepted pair appears after 1 cycle.
- Backpressure: accept (1,1), hold out_ready=0 for 3 cycles while driving (0,1) -> in_ready=0, carry=1/sum=0 stable; raise out_ready -> (0,1) accepted same cycle, next cycle sum=1, carry=0.
- Simultaneous transfer: out_valid=1, out_ready=1, in_valid=1 with (1,0) -> next cycle out_valid remains 1, sum=1, carry=0, no idle cycle.
- Mid-operation reset: out_valid=1 holding (1,1) result, pulse rst_n low between clock edges -> outputs clear immediately, no result delivered.
- WIDTH=4: a=4'b1100, b=4'b1010 -> sum=4'b0110, carry=4'b1000 after 1 cycle.
